fpga_boot_sequencer: RTL

//  Sequences heepstor_top bring-up on FPGA boards, sitting between clock wizard, board pins and SoC.
//  - Waits for the clock wizard lock, then debounces and latches the boot straps.
//  - Holds the SoC in reset for a fixed window, then releases it.
//  - Captures the exit status (exit_valid/exit_value) for LEDs.
//  - Re-runs the sequence when the clock lock is lost.

---
 rtl/fpga_boot_seq_pkg.sv | 26 ++
 rtl/fpga_sync_2ff.sv | 23 ++
 rtl/fpga_boot_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fpga_boot_seq_pkg.sv
// Shared state encoding, strap payload and sizing helpers for the FPGA boot sequencer.
package fpga_boot_seq_pkg;

  localparam int unsigned CNT_W_DEFAULT = 24;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    DEBOUNCE  = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } state_e;

  typedef struct packed {
    logic boot_select;
    logic execute_from_flash;
  } strap_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fpga_sync_2ff.sv
// Two-flop synchroniser bank for asynchronous board-level inputs.
module fpga_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fpga_boot_sequencer.sv
// FPGA bring-up sequencer: lock wait, strap debounce, SoC reset hold, exit capture.
// Define FPGA_BOOT_SEQ_WDT_EN to enable the RUN-state watchdog.
module fpga_boot_sequencer
  import fpga_boot_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned WDT_CYCLES      = 32'd16777216,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        clk_locked_i,
  input  logic        boot_select_pin_i,
  input  logic        exec_flash_pin_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        soc_rst_no,
  output logic        boot_select_o,
  output logic        execute_from_flash_o,
  output logic        exit_done_o,
  output logic        exit_pass_o,
  output logic [7:0]  exit_code_o,
  output logic        wdt_timeout_o,
  output logic [2:0]  state_o
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TOP   =
    CNT_W'(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, WDT_CYCLES) - 1);
`ifdef FPGA_BOOT_SEQ_WDT_EN
  localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES - 1);
`endif

  logic [2:0]       sync_q;
  logic             lock_s;
  strap_t           strap_s;
  strap_t           strap_prev;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             count;
  logic             clr;
  logic             latch;
  logic             capture;
`ifdef FPGA_BOOT_SEQ_WDT_EN
  logic             wdt_hit;
  logic             wdt_q;
`endif

  fpga_sync_2ff #(.WIDTH(3)) u_sync (
    .clk   (clk_gen),
    .rst_n (rst_n),
    .d     ({clk_locked_i, boot_select_pin_i, exec_flash_pin_i}),
    .q     (sync_q)
  );

  assign lock_s  = sync_q[2];
  assign strap_s = strap_t'(sync_q[1:0]);
  assign state_o = state_q;

  // Next-state and counter control; lock loss overrides every other decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count   = 1'b0;
    clr     = 1'b0;
    latch   = 1'b0;
    capture = 1'b0;
`ifdef FPGA_BOOT_SEQ_WDT_EN
    wdt_hit = 1'b0;
`endif
    case (state_q)
      WAIT_LOCK: if (lock_s) state_d = DEBOUNCE;
      DEBOUNCE: begin
        if (strap_s != strap_prev) begin
          clr = 1'b1;
        end else if (cnt_q == DEB_LAST) begin
          latch   = 1'b1;
          state_d = HOLD;
        end else begin
          count = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = RUN;
        else                    count   = 1'b1;
      end
      RUN: begin
        if (exit_valid_i) begin
          capture = 1'b1;
          state_d = DONE;
        end
`ifdef FPGA_BOOT_SEQ_WDT_EN
        else if (cnt_q == WDT_LAST) begin
          wdt_hit = 1'b1;
          state_d = HOLD;
        end else begin
          count = 1'b1;
        end
`endif
      end
      DONE:    state_d = DONE;
      default: state_d = WAIT_LOCK;
    endcase

    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d = WAIT_LOCK;
      latch   = 1'b0;
      capture = 1'b0;
`ifdef FPGA_BOOT_SEQ_WDT_EN
      wdt_hit = 1'b0;
`endif
    end

    // Saturating increment keeps the counter from ever wrapping.
    if (state_d != state_q || clr) cnt_d = '0;
    else if (count)               cnt_d = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= WAIT_LOCK;
      cnt_q                <= '0;
      strap_prev           <= '0;
      soc_rst_no           <= 1'b0;
      boot_select_o        <= 1'b0;
      execute_from_flash_o <= 1'b0;
      exit_done_o          <= 1'b0;
      exit_pass_o          <= 1'b0;
      exit_code_o          <= '0;
`ifdef FPGA_BOOT_SEQ_WDT_EN
      wdt_q                <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      strap_prev <= strap_s;
      soc_rst_no <= (state_d == RUN) || (state_d == DONE);
      if (latch) begin
        boot_select_o        <= strap_s.boot_select;
        execute_from_flash_o <= strap_s.execute_from_flash;
      end
      if (state_d == WAIT_LOCK) begin
        exit_done_o <= 1'b0;
        exit_pass_o <= 1'b0;
        exit_code_o <= '0;
      end else if (capture) begin
        exit_done_o <= 1'b1;
        exit_pass_o <= (exit_value_i == 32'd0);
        exit_code_o <= exit_value_i[7:0];
      end
`ifdef FPGA_BOOT_SEQ_WDT_EN
      if (wdt_hit) wdt_q <= 1'b1;
`endif
    end
  end

`ifdef FPGA_BOOT_SEQ_WDT_EN
  assign wdt_timeout_o = wdt_q;
`else
  assign wdt_timeout_o = 1'b0;
`endif

endmodule
